// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive bit-timing slice:
//   state_t        - bit-timer FSM states (IDLE, RUN, DONE)
//   MIN_PRESCALE   - smallest legal oversampling ratio
//   *_W_DEF        - default counter widths used by the timer and sampler
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W_DEF = 6;
  localparam int unsigned BIT_CNT_W_DEF  = 4;
  localparam int unsigned MIN_PRESCALE   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler
// Mid-bit sampler for the UART receive bit timer.
// Build option: UART_RX_MAJORITY_SAMPLE_EN selects 3-point majority voting
// (samples at mid-1, mid, mid+1) instead of a single sample at mid.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   i_sample_en       - timer is counting a bit and not aborting this cycle
//   i_edge_count      - edge index within the current bit
//   i_prescale        - oversampling ratio (mid = prescale >> 1)
//   i_rx              - synchronised serial line
//   o_sampled_bit     - registered sampled value of the bit
//   o_sampled_valid   - 1-cycle pulse when o_sampled_bit was updated
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sample_en,
  input  logic [PRESCALE_W-1:0] i_edge_count,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_rx,
  output logic                  o_sampled_bit,
  output logic                  o_sampled_valid
);

  logic [PRESCALE_W-1:0] w_mid;
  logic                  r_bit;
  logic                  r_valid;

  assign w_mid = i_prescale >> 1;

`ifdef UART_RX_MAJORITY_SAMPLE_EN
  logic [1:0] r_shift;
  logic       w_hit_lo;
  logic       w_hit_mid;
  logic       w_hit_hi;
  logic       w_vote;

  assign w_hit_lo  = i_sample_en && (i_edge_count == (w_mid - PRESCALE_W'(1)));
  assign w_hit_mid = i_sample_en && (i_edge_count == w_mid);
  assign w_hit_hi  = i_sample_en && (i_edge_count == (w_mid + PRESCALE_W'(1)));

  // The third sample is voted directly from the line, so the result is
  // ready at the mid+1 edge without a further shift stage.
  assign w_vote = (r_shift[1] & r_shift[0]) | (r_shift[1] & i_rx) | (r_shift[0] & i_rx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_hit_hi;
      if (w_hit_lo || w_hit_mid) begin
        r_shift <= {r_shift[0], i_rx};
      end
      if (w_hit_hi) begin
        r_bit <= w_vote;
      end
    end
  end
`else
  logic w_hit_mid;

  assign w_hit_mid = i_sample_en && (i_edge_count == w_mid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_hit_mid;
      if (w_hit_mid) begin
        r_bit <= i_rx;
      end
    end
  end
`endif

  assign o_sampled_bit   = r_bit;
  assign o_sampled_valid = r_valid;

endmodule

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer
// Bit-timing engine for the UART receiver: counts oversampling edges per bit
// and bits per frame, samples the line mid-bit and flags bit/frame/abort events.
// Build option: UART_RX_MAJORITY_SAMPLE_EN enables 3-point majority sampling
// (see uart_rx_bit_sampler); bit and frame timing is the same in both builds.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   prescale            - oversampling ratio, legal 4..2^PRESCALE_W-1
//   enable              - level; start/continue bit timing
//   disable_bit_count   - synchronous abort
//   frame_bits          - bits per frame, legal 1..2^BIT_CNT_W-1
//   rx_in               - synchronised serial line
//   edge_count          - edge index within the current bit
//   bit_count           - bit index within the frame
//   sampled_bit         - registered sampled bit value
//   sampled_valid       - 1-cycle pulse, sampled_bit updated
//   bit_done            - pulse on the last edge of each bit
//   frame_done          - pulse on the last edge of the last bit
//   aborted             - pulse the cycle after a running frame is cancelled
//   cfg_err             - combinational, prescale < 4 or frame_bits == 0
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  enable,
  input  logic                  disable_bit_count,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  input  logic                  rx_in,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sampled_bit,
  output logic                  sampled_valid,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  aborted,
  output logic                  cfg_err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_edge;
  logic [PRESCALE_W-1:0] w_edge_nxt;
  logic [BIT_CNT_W-1:0]  r_bit;
  logic [BIT_CNT_W-1:0]  w_bit_nxt;
  logic                  r_aborted;
  logic                  w_abort;
  logic                  w_last_edge;
  logic                  w_last_bit;
  logic                  w_bit_done;
  logic                  w_frame_done;
  logic                  w_sample_en;

  assign cfg_err = (prescale < PRESCALE_W'(MIN_PRESCALE)) || (frame_bits == '0);

  assign w_last_edge = (r_edge == (r_prescale - PRESCALE_W'(1)));
  // >= keeps bit_count below frame_bits even if frame_bits shrinks mid-frame
  assign w_last_bit  = (frame_bits == '0) || (r_bit >= (frame_bits - BIT_CNT_W'(1)));

  always_comb begin
    w_state_nxt  = r_state;
    w_edge_nxt   = '0;
    w_bit_nxt    = '0;
    w_abort      = 1'b0;
    w_bit_done   = 1'b0;
    w_frame_done = 1'b0;
    w_sample_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !cfg_err && !disable_bit_count) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // A prescale change shows up as a mismatch against last cycle's value,
        // which also covers prescale dropping into the illegal range.
        w_abort = !enable || disable_bit_count || (prescale != r_prescale);
        if (w_abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_sample_en = 1'b1;
          if (w_last_edge) begin
            w_bit_done = 1'b1;
            if (w_last_bit) begin
              w_frame_done = 1'b1;
              w_state_nxt  = DONE;
            end else begin
              w_bit_nxt = r_bit + BIT_CNT_W'(1);
            end
          end else begin
            w_edge_nxt = r_edge + PRESCALE_W'(1);
            w_bit_nxt  = r_bit;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prescale <= '0;
      r_edge     <= '0;
      r_bit      <= '0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prescale <= prescale;
      r_edge     <= w_edge_nxt;
      r_bit      <= w_bit_nxt;
      r_aborted  <= w_abort;
    end
  end

  uart_rx_bit_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .i_sample_en     (w_sample_en),
    .i_edge_count    (r_edge),
    .i_prescale      (prescale),
    .i_rx            (rx_in),
    .o_sampled_bit   (sampled_bit),
    .o_sampled_valid (sampled_valid)
  );

  assign edge_count = r_edge;
  assign bit_count  = r_bit;
  assign bit_done   = w_bit_done;
  assign frame_done = w_frame_done;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb_uart_rx_bit_timer
// Self-checking bench for uart_rx_bit_timer. A frame-level model (cycle index
// within the frame, divided/modulo by the prescale) predicts every output on
// each falling edge; directed scenarios add hand-computed literal checks.
module tb_uart_rx_bit_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       enable = 1'b0;
  logic       dis = 1'b0;
  logic [3:0] frame_bits = 4'd10;
  logic       rx = 1'b1;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sampled_valid;
  logic       bit_done;
  logic       frame_done;
  logic       aborted;
  logic       cfg_err;

  always #5 clk = ~clk;

  uart_rx_bit_timer #(
    .PRESCALE_W (6),
    .BIT_CNT_W  (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .prescale          (prescale),
    .enable            (enable),
    .disable_bit_count (dis),
    .frame_bits        (frame_bits),
    .rx_in             (rx),
    .edge_count        (edge_count),
    .bit_count         (bit_count),
    .sampled_bit       (sampled_bit),
    .sampled_valid     (sampled_valid),
    .bit_done          (bit_done),
    .frame_done        (frame_done),
    .aborted           (aborted),
    .cfg_err           (cfg_err)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model state: m_n = cycle index within the running frame, -1 when idle.
  int  m_n = -1;
  int  m_gap = 0;
  int  m_p = 0;
  int  m_prev_p = 0;
  bit  m_ab = 1'b0;
  bit  m_sv = 1'b0;
  bit  m_sb = 1'b0;
  bit  [2:0] m_vote = '0;
  int  cyc = 0;
  int  bd_q[$];
  int  fd_q[$];
  bit  sv_q[$];

  always @(negedge clk) begin : compare
    int e_edge;
    int e_bit;
    int mid;
    bit run;
    bit abn;
    bit e_bd;
    bit e_fd;
    bit e_cfg;
    bit next_sv;
    cyc++;
    e_cfg = (prescale < 6'd4) || (frame_bits == 4'd0);
    check("cfg_err", cfg_err, e_cfg);
    if (rst) begin
      m_n = -1; m_gap = 0; m_prev_p = 0;
      m_ab = 0; m_sv = 0; m_sb = 0; m_vote = '0;
      check("rst_edge_count", edge_count, 0);
      check("rst_bit_count", bit_count, 0);
      check("rst_sampled_bit", sampled_bit, 0);
      check("rst_sampled_valid", sampled_valid, 0);
      check("rst_bit_done", bit_done, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_aborted", aborted, 0);
    end else begin
      run = (m_n >= 0);
      if (run && m_n == 0) m_p = prescale;
      e_edge = run ? (m_n % m_p) : 0;
      e_bit  = run ? (m_n / m_p) : 0;
      abn  = run && (!enable || dis || (int'(prescale) != m_prev_p));
      e_bd = run && !abn && (e_edge == m_p - 1);
      e_fd = e_bd && (e_bit == int'(frame_bits) - 1);
      check("edge_count", edge_count, e_edge);
      check("bit_count", bit_count, e_bit);
      check("bit_done", bit_done, e_bd);
      check("frame_done", frame_done, e_fd);
      check("aborted", aborted, m_ab);
      check("sampled_valid", sampled_valid, m_sv);
      check("sampled_bit", sampled_bit, m_sb);
      if (bit_done) bd_q.push_back(cyc);
      if (frame_done) fd_q.push_back(cyc);
      if (sampled_valid) sv_q.push_back(sampled_bit);
      next_sv = 1'b0;
      if (run && !abn) begin
        mid = m_p / 2;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
        if (e_edge >= mid - 1 && e_edge <= mid + 1) m_vote[e_edge - mid + 1] = rx;
        if (e_edge == mid + 1) begin
          m_sb = (int'(m_vote[0]) + int'(m_vote[1]) + int'(m_vote[2])) >= 2;
          next_sv = 1'b1;
        end
`else
        if (e_edge == mid) begin
          m_sb = rx;
          next_sv = 1'b1;
        end
`endif
      end
      m_sv = next_sv;
      m_ab = abn;
      if (run) begin
        if (abn) m_n = -1;
        else if (e_fd) begin m_n = -1; m_gap = 1; end
        else m_n++;
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (enable && !e_cfg && !dis) begin
        m_n = 0;
      end
      m_prev_p = prescale;
    end
  end

  // rx_mode 0: idle high; 1: toggle per bit (bit i = i%2); 2: 0 only at edge 4
  int rx_mode = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      case (rx_mode)
        1: rx = (m_n >= 0) ? (((m_n / int'(prescale)) % 2) == 1) : 1'b1;
        2: rx = (m_n == 4) ? 1'b0 : 1'b1;
        default: rx = 1'b1;
      endcase
    end
  endtask

  task automatic wait_n(input int target, input int bound);
    int found = 0;
    for (int i = 0; i < bound && found == 0; i++) begin
      tick(1);
      if (m_n == target) found = 1;
    end
    if (found == 0) check("wait_n_timeout", found, 1);
  endtask

  task automatic wait_fd(input int count, input int bound);
    int found = 0;
    for (int i = 0; i < bound && found == 0; i++) begin
      tick(1);
      if (fd_q.size() >= count) found = 1;
    end
    if (found == 0) check("wait_fd_timeout", found, 1);
  endtask

  task automatic clear_logs();
    bd_q.delete();
    fd_q.delete();
    sv_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int en_cyc;
    int v;
    tick(3);
    check("reset_edge", edge_count, 0);
    check("reset_bit", bit_count, 0);
    check("reset_aborted", aborted, 0);
    rst = 1'b0;
    tick(2);

    // Nominal frame: prescale 8, 10 bits, toggling line
    clear_logs();
    prescale = 6'd8; frame_bits = 4'd10; rx_mode = 1;
    enable = 1'b1; en_cyc = cyc + 1;
    wait_fd(1, 200);
    enable = 1'b0;
    tick(4);
    check("t1_bd_count", bd_q.size(), 10);
    check("t1_bd_spacing", bd_q[1] - bd_q[0], 8);
    check("t1_fd_after_first_bd", fd_q[0] - bd_q[0], 72);
    check("t1_fd_run_cycle", fd_q[0] - en_cyc, 80);
    check("t1_sample_count", sv_q.size(), 10);
    v = 0;
    foreach (sv_q[i]) v = v | (int'(sv_q[i]) << i);
    check("t1_sample_pattern", v, 32'h2AA);

    // Odd prescale, two back-to-back frames with enable held high
    clear_logs();
    prescale = 6'd5; frame_bits = 4'd3;
    enable = 1'b1; en_cyc = cyc + 1;
    wait_fd(2, 200);
    enable = 1'b0;
    tick(4);
    check("t2_fd_run_cycle", fd_q[0] - en_cyc, 15);
    check("t2_fd_after_first_bd", fd_q[0] - bd_q[0], 10);
    check("t2_frame_gap", bd_q[3] - fd_q[0], 7);
    check("t2_bd_count", bd_q.size(), 6);

    // Prescale change at bit 3 edge 6
    clear_logs();
    prescale = 6'd16; frame_bits = 4'd10;
    enable = 1'b1;
    wait_n(3 * 16 + 6, 300);
    prescale = 6'd8;
    tick(1);
    check("t3_aborted", aborted, 1);
    check("t3_edge", edge_count, 0);
    check("t3_bit", bit_count, 0);
    enable = 1'b0;
    tick(3);
    check("t3_idle_edge", edge_count, 0);
    check("t3_no_fd", fd_q.size(), 0);
    check("t3_bd_count", bd_q.size(), 3);

    // disable_bit_count pulse mid-frame with enable held high
    clear_logs();
    prescale = 6'd8; frame_bits = 4'd10;
    enable = 1'b1;
    wait_n(20, 200);
    dis = 1'b1;
    tick(1);
    dis = 1'b0;
    check("t4_aborted", aborted, 1);
    tick(1);
    check("t4_restart_edge", edge_count, 0);
    check("t4_restart_bit", bit_count, 0);
    tick(1);
    check("t4_restart_edge1", edge_count, 1);
    wait_fd(1, 200);
    enable = 1'b0;
    tick(4);
    check("t4_bd_count", bd_q.size(), 12);

    // Glitch to 0 only at edge 4 of a 1-bit
    clear_logs();
    prescale = 6'd8; frame_bits = 4'd2; rx_mode = 2;
    enable = 1'b1;
    wait_fd(1, 100);
    enable = 1'b0;
    tick(4);
    check("t5_sample_count", sv_q.size(), 2);
`ifdef UART_RX_MAJORITY_SAMPLE_EN
    check("t5_glitch_bit", sv_q[0], 1);
`else
    check("t5_glitch_bit", sv_q[0], 0);
`endif

    // Configuration errors keep the block idle
    clear_logs();
    rx_mode = 1;
    prescale = 6'd3; frame_bits = 4'd10;
    enable = 1'b1;
    tick(1);
    check("t6_cfg_err_prescale", cfg_err, 1);
    tick(5);
    check("t6_idle_edge", edge_count, 0);
    check("t6_no_bd", bd_q.size(), 0);
    prescale = 6'd8; frame_bits = 4'd0;
    tick(2);
    check("t6_cfg_err_frame_bits", cfg_err, 1);
    check("t6_idle_bit", bit_count, 0);
    enable = 1'b0; frame_bits = 4'd10;
    tick(3);

    // Asynchronous reset at bit 2
    clear_logs();
    prescale = 6'd8; frame_bits = 4'd10;
    enable = 1'b1;
    wait_n(20, 200);
    check("t7_pre_rst_sampled", sampled_bit, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_edge", edge_count, 0);
    check("t7_rst_bit", bit_count, 0);
    check("t7_rst_sampled_bit", sampled_bit, 0);
    check("t7_rst_sampled_valid", sampled_valid, 0);
    check("t7_rst_bit_done", bit_done, 0);
    check("t7_rst_frame_done", frame_done, 0);
    check("t7_rst_aborted", aborted, 0);
    enable = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("t7_no_abort_after_rst", aborted, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
